// File: rtl/chrono_pkg.sv
// ============================================================================
// Module   : chrono_pkg
// Brief    : Shared state codes and BCD digit constants for the lap chrono.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package chrono_pkg;

    localparam int                   c_DIGIT_W   = 4;
    localparam logic [c_DIGIT_W-1:0] c_DIGIT_MAX = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STOP   = 3'd2,
        ST_LAP    = 3'd3,
        ST_RECALL = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/chrono_bcd_counter.sv
// ============================================================================
// Module   : chrono_bcd_counter
// Brief    : N-digit BCD up-counter with ripple carry and wrap indication.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chrono_bcd_counter
    import chrono_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_tick,
    input  logic                          i_clear,
    output logic [c_DIGIT_W*N_DIGITS-1:0] o_count,
    output logic                          o_carry
);

    // w_carry[i] is the increment request reaching digit i
    logic [N_DIGITS:0] w_carry;

    assign w_carry[0] = i_tick;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            logic [c_DIGIT_W-1:0] r_digit;

            assign w_carry[gi+1] = w_carry[gi] && (r_digit == c_DIGIT_MAX);

            always_ff @(posedge clk) begin
                if (rst || i_clear) begin
                    r_digit <= '0;
                end else if (w_carry[gi]) begin
                    r_digit <= (r_digit == c_DIGIT_MAX) ? '0 : r_digit + c_DIGIT_W'(1);
                end
            end

            assign o_count[gi*c_DIGIT_W +: c_DIGIT_W] = r_digit;
        end
    endgenerate

    assign o_carry = w_carry[N_DIGITS];

endmodule

`default_nettype wire

// File: rtl/lap_memory_chrono.sv
// ============================================================================
// Module   : lap_memory_chrono
// Brief    : Stopwatch with BCD counter, lap ring buffer and lap recall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lap_memory_chrono
    import chrono_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int LAP_DEPTH = 4
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          ss_pulse,
    input  logic                          lr_pulse,
    input  logic                          recall_pulse,
    output logic [c_DIGIT_W*N_DIGITS-1:0] display,
    output logic [2:0]                    state,
    output logic                          lap_flag,
    output logic                          running,
    output logic [4:0]                    lap_count,
    output logic [3:0]                    recall_idx,
    output logic                          overrun,
    output logic                          overflow
);

    localparam int         c_W     = c_DIGIT_W * N_DIGITS;
    localparam int         c_PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam logic [4:0] c_DEPTH = 5'(LAP_DEPTH);

    state_t             r_state;
    state_t             w_next;
    logic [c_W-1:0]     w_count;
    logic               w_wrap;
    logic [c_W-1:0]     r_lap_mem [LAP_DEPTH];
    logic [4:0]         r_wr_ptr;
    logic [4:0]         r_lap_count;
    logic [3:0]         r_recall_idx;
    logic               r_overrun;
    logic               r_overflow;
    logic [c_W-1:0]     r_display;

    logic               w_counting;
    logic               w_capture;
    logic               w_clear;
    logic               w_recall_start;
    logic               w_recall_step;
    logic [4:0]         w_idx_inc;
    logic [4:0]         w_oldest;
    logic [4:0]         w_rsum;
    logic [c_PTR_W-1:0] w_raddr;
    logic [c_PTR_W-1:0] w_newest;

    // ss_pulse outranks lr_pulse, which outranks recall_pulse
    assign w_counting     = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign w_capture      = w_counting && lr_pulse && !ss_pulse;
    assign w_clear        = (r_state == ST_STOP) && lr_pulse && !ss_pulse;
    assign w_recall_start = (r_state == ST_STOP) && (w_next == ST_RECALL);
    assign w_recall_step  = (r_state == ST_RECALL) && recall_pulse && !ss_pulse && !lr_pulse;
    assign w_idx_inc      = {1'b0, r_recall_idx} + 5'd1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (ss_pulse) w_next = ST_RUN;
            ST_RUN:    if (ss_pulse) w_next = ST_STOP;
                       else if (lr_pulse) w_next = ST_LAP;
            ST_LAP:    if (ss_pulse) w_next = ST_STOP;
            ST_STOP:   if (ss_pulse) w_next = ST_RUN;
                       else if (lr_pulse) w_next = ST_IDLE;
                       else if (recall_pulse && (r_lap_count != 5'd0)) w_next = ST_RECALL;
            ST_RECALL: if (ss_pulse || lr_pulse) w_next = ST_STOP;
            default:   w_next = ST_IDLE;
        endcase
    end

    chrono_bcd_counter #(
        .N_DIGITS (N_DIGITS)
    ) u_counter (
        .clk     (clk_in),
        .rst     (reset),
        .i_tick  (tick && w_counting),
        .i_clear (w_clear),
        .o_count (w_count),
        .o_carry (w_wrap)
    );

    // Once the ring is full the write pointer also marks the oldest entry
    assign w_oldest = (r_lap_count == c_DEPTH) ? r_wr_ptr : 5'd0;
    assign w_rsum   = w_oldest + {1'b0, r_recall_idx};
    assign w_raddr  = (w_rsum >= c_DEPTH) ? c_PTR_W'(w_rsum - c_DEPTH) : c_PTR_W'(w_rsum);
    assign w_newest = (r_wr_ptr == 5'd0) ? c_PTR_W'(c_DEPTH - 5'd1) : c_PTR_W'(r_wr_ptr - 5'd1);

    always_ff @(posedge clk_in) begin
        if (!reset && w_capture) begin
            r_lap_mem[c_PTR_W'(r_wr_ptr)] <= w_count;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_lap_count  <= '0;
            r_recall_idx <= '0;
            r_overrun    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_wr_ptr     <= '0;
                r_lap_count  <= '0;
                r_recall_idx <= '0;
                r_overrun    <= 1'b0;
                r_overflow   <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_wr_ptr <= (r_wr_ptr == c_DEPTH - 5'd1) ? 5'd0 : r_wr_ptr + 5'd1;
                    if (r_lap_count == c_DEPTH) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_lap_count <= r_lap_count + 5'd1;
                    end
                end
                if (w_wrap) begin
                    r_overflow <= 1'b1;
                end
                if (w_recall_start) begin
                    r_recall_idx <= '0;
                end else if (w_recall_step) begin
                    r_recall_idx <= (w_idx_inc == r_lap_count) ? 4'd0 : w_idx_inc[3:0];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_display <= '0;
        end else begin
            case (r_state)
                ST_LAP:    r_display <= r_lap_mem[w_newest];
                ST_RECALL: r_display <= r_lap_mem[w_raddr];
                default:   r_display <= w_count;
            endcase
        end
    end

    assign display    = r_display;
    assign state      = r_state;
    assign lap_flag   = (r_state == ST_LAP) || (r_state == ST_RECALL);
    assign running    = w_counting;
    assign lap_count  = r_lap_count;
    assign recall_idx = r_recall_idx;
    assign overrun    = r_overrun;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_lap_memory_chrono.sv
// ============================================================================
// Module   : tb_lap_memory_chrono
// Brief    : Self-checking bench for lap_memory_chrono against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lap_memory_chrono;

    localparam int N_DIGITS  = 4;
    localparam int LAP_DEPTH = 4;
    localparam int c_MOD     = 10000;

    logic        clk_in       = 1'b0;
    logic        reset        = 1'b0;
    logic        tick         = 1'b0;
    logic        ss_pulse     = 1'b0;
    logic        lr_pulse     = 1'b0;
    logic        recall_pulse = 1'b0;
    logic [15:0] display;
    logic [2:0]  state;
    logic        lap_flag;
    logic        running;
    logic [4:0]  lap_count;
    logic [3:0]  recall_idx;
    logic        overrun;
    logic        overflow;

    int errors      = 0;
    int checks      = 0;
    int fail_prints = 0;

    always #5 clk_in = ~clk_in;

    lap_memory_chrono #(
        .N_DIGITS  (N_DIGITS),
        .LAP_DEPTH (LAP_DEPTH)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .tick         (tick),
        .ss_pulse     (ss_pulse),
        .lr_pulse     (lr_pulse),
        .recall_pulse (recall_pulse),
        .display      (display),
        .state        (state),
        .lap_flag     (lap_flag),
        .running      (running),
        .lap_count    (lap_count),
        .recall_idx   (recall_idx),
        .overrun      (overrun),
        .overflow     (overflow)
    );

    // Behavioural model: integer count, laps held oldest-first in a queue
    int          m_state;
    int          m_count;
    int          m_idx;
    int          m_laps[$];
    bit          m_overrun;
    bit          m_overflow;
    bit          m_valid = 1'b0;
    logic [15:0] m_disp;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          d;
        r = '0;
        d = v;
        for (int i = 0; i < N_DIGITS; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 30) begin
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            end
            fail_prints++;
        end
    endtask

    always @(posedge clk_in) begin : model
        bit counting;
        bit capture;
        int ns;
        if (reset) begin
            m_state    = 0;
            m_count    = 0;
            m_idx      = 0;
            m_laps.delete();
            m_overrun  = 1'b0;
            m_overflow = 1'b0;
            m_disp     = '0;
            m_valid    = 1'b1;
        end else if (m_valid) begin
            if (m_state == 3)      m_disp = to_bcd(m_laps[m_laps.size()-1]);
            else if (m_state == 4) m_disp = to_bcd(m_laps[m_idx]);
            else                   m_disp = to_bcd(m_count);

            counting = (m_state == 1) || (m_state == 3);
            capture  = counting && lr_pulse && !ss_pulse;
            if (capture) begin
                if (m_laps.size() == LAP_DEPTH) begin
                    void'(m_laps.pop_front());
                    m_overrun = 1'b1;
                end
                m_laps.push_back(m_count);
            end
            if (counting && tick) begin
                if (m_count == c_MOD - 1) m_overflow = 1'b1;
                m_count = (m_count + 1) % c_MOD;
            end

            ns = m_state;
            case (m_state)
                0: if (ss_pulse) ns = 1;
                1: if (ss_pulse) ns = 2; else if (lr_pulse) ns = 3;
                3: if (ss_pulse) ns = 2;
                2: begin
                    if (ss_pulse) ns = 1;
                    else if (lr_pulse) begin
                        ns         = 0;
                        m_count    = 0;
                        m_idx      = 0;
                        m_laps.delete();
                        m_overrun  = 1'b0;
                        m_overflow = 1'b0;
                    end else if (recall_pulse && m_laps.size() > 0) begin
                        ns    = 4;
                        m_idx = 0;
                    end
                end
                4: begin
                    if (ss_pulse || lr_pulse) ns = 2;
                    else if (recall_pulse) m_idx = (m_idx + 1) % m_laps.size();
                end
                default: ns = 0;
            endcase
            m_state = ns;
        end
    end

    always @(negedge clk_in) begin
        if (m_valid) begin
            chk("state",      32'(state),      32'(m_state));
            chk("display",    32'(display),    32'(m_disp));
            chk("lap_flag",   32'(lap_flag),   32'((m_state == 3) || (m_state == 4)));
            chk("running",    32'(running),    32'((m_state == 1) || (m_state == 3)));
            chk("lap_count",  32'(lap_count),  32'(m_laps.size()));
            chk("recall_idx", 32'(recall_idx), 32'(m_idx));
            chk("overrun",    32'(overrun),    32'(m_overrun));
            chk("overflow",   32'(overflow),   32'(m_overflow));
        end
    end

    task automatic step(input bit t, input bit ss, input bit lr, input bit rc, input bit rs);
        tick         = t;
        ss_pulse     = ss;
        lr_pulse     = lr;
        recall_pulse = rc;
        reset        = rs;
        @(negedge clk_in);
        tick         = 1'b0;
        ss_pulse     = 1'b0;
        lr_pulse     = 1'b0;
        recall_pulse = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1, 0, 0, 0, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [15:0] exp_recall [5];
        int          r;
        exp_recall = '{16'h0030, 16'h0040, 16'h0050, 16'h0060, 16'h0030};

        @(negedge clk_in);

        // reset with every pulse asserted still lands in IDLE
        step(1, 1, 1, 1, 1);
        chk("rst_state",     32'(state),     32'd0);
        chk("rst_display",   32'(display),   32'h0);
        chk("rst_lap_count", 32'(lap_count), 32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);

        // 1234 ticks then stop
        do_reset();
        step(0, 1, 0, 0, 0);
        ticks(1234);
        step(0, 1, 0, 0, 0);
        idle();
        chk("stop_state",   32'(state),   32'd2);
        chk("stop_display", 32'(display), 32'h1234);
        chk("stop_running", 32'(running), 32'd0);

        // capture coincident with tick keeps pre-tick value
        do_reset();
        step(0, 1, 0, 0, 0);
        ticks(50);
        step(1, 0, 1, 0, 0);
        chk("lap_state", 32'(state), 32'd3);
        idle();
        chk("lap_display", 32'(display), 32'h0050);
        step(0, 1, 0, 0, 0);
        idle();
        chk("lap_live", 32'(display), 32'h0051);

        // six captures into a four-deep ring, then recall with wrap
        do_reset();
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            ticks(10);
            step(0, 0, 1, 0, 0);
        end
        chk("ring_count",   32'(lap_count), 32'd4);
        chk("ring_overrun", 32'(overrun),   32'd1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            idle();
            chk("recall_display", 32'(display), 32'(exp_recall[k]));
            step(0, 0, 0, 1, 0);
        end

        // wrap from all nines
        do_reset();
        step(0, 1, 0, 0, 0);
        ticks(9999);
        idle();
        chk("pre_wrap_display",  32'(display),  32'h9999);
        chk("pre_wrap_overflow", 32'(overflow), 32'd0);
        ticks(1);
        idle();
        chk("wrap_display",  32'(display),  32'h0000);
        chk("wrap_overflow", 32'(overflow), 32'd1);

        // ss and lr together in STOP resumes without clearing
        do_reset();
        step(0, 1, 0, 0, 0);
        ticks(5);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        idle();
        chk("sslr_state",     32'(state),     32'd1);
        chk("sslr_lap_count", 32'(lap_count), 32'd1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("clear_state",     32'(state),     32'd0);
        chk("clear_lap_count", 32'(lap_count), 32'd0);

        // reset in the middle of RECALL
        do_reset();
        step(0, 1, 0, 0, 0);
        ticks(3);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("recall_state", 32'(state), 32'd4);
        step(0, 1, 0, 1, 1);
        chk("rec_rst_state",     32'(state),     32'd0);
        chk("rec_rst_display",   32'(display),   32'h0);
        chk("rec_rst_lap_count", 32'(lap_count), 32'd0);

        // randomized traffic checked by the model every cycle
        do_reset();
        for (int n = 0; n < 6000; n++) begin
            r = int'($urandom_range(0, 999));
            step(1'($urandom_range(0, 1)), r < 30, (r >= 30) && (r < 90),
                 (r >= 90) && (r < 250), r == 999);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
